// File: rtl/rc4_encrypt_msg.sv
// RC4 PRGA encryptor: steps the keystream over a KSA-initialised S RAM and
// writes plaintext XOR keystream to the ciphertext RAM, rejecting bytes outside the alphabet.
module rc4_encrypt_msg #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned K_W     = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           em_done,
  output logic           em_invalid,
  output logic [7:0]     s_address,
  output logic [7:0]     s_data,
  output logic           s_wren,
  input  logic [7:0]     s_q,
  output logic [K_W-1:0] pt_address,
  input  logic [7:0]     pt_q,
  output logic [K_W-1:0] ct_address,
  output logic [7:0]     ct_data,
  output logic           ct_wren
);

  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_CLR, S_PT_RD, S_PT_WAIT, S_PT_CHK, S_INC_I,
    S_SI_RD, S_SI_WAIT, S_SI_SAVE, S_CALC_J,
    S_SJ_RD, S_SJ_WAIT, S_SJ_SAVE,
    S_WR_J, S_WR_GAP, S_WR_I,
    S_F_RD, S_F_WAIT, S_F_SAVE,
    S_CT_WR, S_CT_NEXT, S_DONE, S_INVALID
  } state_t;

  state_t         state_q;
  logic [7:0]     i_q, j_q, p_q, si_q, sj_q, f_q;
  logic [K_W-1:0] k_q;
  logic           em_done_q, em_invalid_q, s_wren_q, ct_wren_q;
  logic [7:0]     s_address_q, s_data_q, ct_data_q;
  logic [K_W-1:0] pt_address_q, ct_address_q;

  // Byte is legal only if it is a space or a lowercase letter.
  function automatic logic bad_byte(input logic [7:0] b);
    return ((b < 8'h61) && (b != 8'h20)) || (b > 8'h7A);
  endfunction

  // Each RAM read is address -> wait -> sample, matching the two-clock q latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      p_q          <= '0;
      si_q         <= '0;
      sj_q         <= '0;
      f_q          <= '0;
      em_done_q    <= 1'b0;
      em_invalid_q <= 1'b0;
      s_address_q  <= '0;
      s_data_q     <= '0;
      s_wren_q     <= 1'b0;
      pt_address_q <= '0;
      ct_address_q <= '0;
      ct_data_q    <= '0;
      ct_wren_q    <= 1'b0;
    end else begin
      s_wren_q  <= 1'b0;
      ct_wren_q <= 1'b0;
      case (state_q)
        S_IDLE:    if (start) state_q <= S_CLR;
        S_CLR: begin
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
          state_q <= S_PT_RD;
        end
        S_PT_RD: begin
          pt_address_q <= k_q;
          state_q      <= S_PT_WAIT;
        end
        S_PT_WAIT: state_q <= S_PT_CHK;
        S_PT_CHK: begin
          p_q <= pt_q;
          if (bad_byte(pt_q)) begin
            em_invalid_q <= 1'b1;
            state_q      <= S_INVALID;
          end else begin
            state_q <= S_INC_I;
          end
        end
        S_INC_I: begin
          i_q     <= i_q + 8'd1;
          state_q <= S_SI_RD;
        end
        S_SI_RD: begin
          s_address_q <= i_q;
          state_q     <= S_SI_WAIT;
        end
        S_SI_WAIT: state_q <= S_SI_SAVE;
        S_SI_SAVE: begin
          si_q    <= s_q;
          state_q <= S_CALC_J;
        end
        S_CALC_J: begin
          j_q     <= j_q + si_q;
          state_q <= S_SJ_RD;
        end
        S_SJ_RD: begin
          s_address_q <= j_q;
          state_q     <= S_SJ_WAIT;
        end
        S_SJ_WAIT: state_q <= S_SJ_SAVE;
        S_SJ_SAVE: begin
          sj_q    <= s_q;
          state_q <= S_WR_J;
        end
        // Gap state keeps the two swap writes as separate one-cycle pulses.
        S_WR_J: begin
          s_address_q <= j_q;
          s_data_q    <= si_q;
          s_wren_q    <= 1'b1;
          state_q     <= S_WR_GAP;
        end
        S_WR_GAP:  state_q <= S_WR_I;
        S_WR_I: begin
          s_address_q <= i_q;
          s_data_q    <= sj_q;
          s_wren_q    <= 1'b1;
          state_q     <= S_F_RD;
        end
        S_F_RD: begin
          s_address_q <= si_q + sj_q;
          state_q     <= S_F_WAIT;
        end
        S_F_WAIT:  state_q <= S_F_SAVE;
        S_F_SAVE: begin
          f_q     <= s_q;
          state_q <= S_CT_WR;
        end
        S_CT_WR: begin
          ct_address_q <= k_q;
          ct_data_q    <= p_q ^ f_q;
          ct_wren_q    <= 1'b1;
          state_q      <= S_CT_NEXT;
        end
        S_CT_NEXT: begin
          if (k_q == K_LAST) begin
            em_done_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            k_q     <= k_q + K_W'(1);
            state_q <= S_PT_RD;
          end
        end
        S_DONE:    state_q <= S_DONE;
        S_INVALID: state_q <= S_INVALID;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign em_done    = em_done_q;
  assign em_invalid = em_invalid_q;
  assign s_address  = s_address_q;
  assign s_data     = s_data_q;
  assign s_wren     = s_wren_q;
  assign pt_address = pt_address_q;
  assign ct_address = ct_address_q;
  assign ct_data    = ct_data_q;
  assign ct_wren    = ct_wren_q;

endmodule

// File: tb/tb_rc4_encrypt_msg.sv
// Bench for rc4_encrypt_msg: synchronous RAM models, table of message/S setups,
// RC4 reference model, mid-run reset, held start and a KSA round trip.
module tb_rc4_encrypt_msg;

  localparam int unsigned MSG_LEN = 32;
  localparam int unsigned K_W     = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           em_done, em_invalid;
  logic [7:0]     s_address, s_data, s_q;
  logic           s_wren;
  logic [K_W-1:0] pt_address, ct_address;
  logic [7:0]     pt_q, ct_data;
  logic           ct_wren;

  rc4_encrypt_msg #(.MSG_LEN(MSG_LEN), .K_W(K_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .em_done(em_done), .em_invalid(em_invalid),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .pt_address(pt_address), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  logic [7:0]         s_init [256];
  logic [7:0]         s_mem  [256];
  logic [7:0]         pt_mem [MSG_LEN];
  logic [7:0]         ct_mem [MSG_LEN];
  logic [MSG_LEN-1:0] ct_mask;
  logic               load_s = 1'b0;
  int                 wr_count = 0;
  bit                 both_seen = 1'b0;

  // Synchronous RAMs: q registered from the address, writes on the clock edge.
  always @(posedge clk) begin
    if (load_s) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
      for (int a = 0; a < MSG_LEN; a++) ct_mem[a] <= 8'h00;
      ct_mask <= '0;
    end else begin
      if (s_wren) s_mem[s_address] <= s_data;
      if (ct_wren) begin
        ct_mem[ct_address]  <= ct_data;
        ct_mask[ct_address] <= 1'b1;
        wr_count            <= wr_count + 1;
      end
    end
    s_q  <= s_mem[s_address];
    pt_q <= pt_mem[pt_address];
  end

  always @(negedge clk) if (em_done && em_invalid) both_seen <= 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference RC4 PRGA over m_s; stops at the first illegal byte when check_alpha is set.
  logic [7:0] m_s   [256];
  logic [7:0] m_in  [MSG_LEN];
  logic [7:0] m_out [MSG_LEN];
  int         m_n;

  function automatic bit legal(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  task automatic model_rc4(input bit check_alpha);
    int i, j, t;
    logic [7:0] tmp;
    i = 0; j = 0; m_n = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (check_alpha && !legal(m_in[k])) return;
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      tmp = m_s[i]; m_s[i] = m_s[j]; m_s[j] = tmp;
      t = (int'(m_s[i]) + int'(m_s[j])) % 256;
      m_out[k] = m_in[k] ^ m_s[t];
      m_n++;
    end
  endtask

  task automatic ksa(input logic [23:0] key);
    int j;
    logic [7:0] kb [3];
    logic [7:0] tmp;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + int'(s_init[a]) + int'(kb[a % 3])) % 256;
      tmp = s_init[a]; s_init[a] = s_init[j]; s_init[j] = tmp;
    end
  endtask

  function automatic logic [7:0] rand_char();
    int n;
    n = int'($urandom_range(0, 26));
    return (n == 0) ? 8'h20 : 8'(8'h60 + n);
  endfunction

  task automatic make_s(input int kind);
    int r;
    logic [7:0] tmp;
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    if (kind == 1) begin
      s_init[1] = 8'hFF; s_init[255] = 8'h01;
    end else if (kind == 2) begin
      for (int a = 255; a > 0; a--) begin
        r = int'($urandom_range(0, a));
        tmp = s_init[a]; s_init[a] = s_init[r]; s_init[r] = tmp;
      end
    end
  endtask

  task automatic make_pt(input int kind);
    logic [7:0] edge_set [3];
    edge_set[0] = 8'h20; edge_set[1] = 8'h7A; edge_set[2] = 8'h61;
    for (int k = 0; k < MSG_LEN; k++) begin
      case (kind)
        0:       pt_mem[k] = 8'h61;
        1:       pt_mem[k] = rand_char();
        default: pt_mem[k] = edge_set[k % 3];
      endcase
    end
  endtask

  task automatic load_and_reset();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(em_done || em_invalid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk({name, "_timeout"}, 64'(n), 64'(0));
    repeat (4) @(negedge clk);
  endtask

  // Compares ct RAM and final S against the model seeded from s_init / pt_mem.
  task automatic check_vs_model(input string name, input int exp_writes);
    int bad_ct, bad_s;
    logic [MSG_LEN-1:0] exp_mask;
    for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
    for (int k = 0; k < MSG_LEN; k++) m_in[k] = pt_mem[k];
    model_rc4(1'b1);
    exp_mask = '0;
    for (int k = 0; k < exp_writes; k++) exp_mask[k] = 1'b1;
    chk({name, "_ct_mask"}, 64'(ct_mask), 64'(exp_mask));
    bad_ct = 0;
    for (int k = 0; k < m_n; k++) if (ct_mem[k] !== m_out[k]) bad_ct++;
    chk({name, "_ct_bytes_wrong"}, 64'(bad_ct), 64'(0));
    bad_s = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad_s++;
    chk({name, "_s_entries_wrong"}, 64'(bad_s), 64'(0));
  endtask

  typedef struct {
    int         s_kind;
    int         pt_kind;
    int         bad_idx;
    logic [7:0] bad_val;
    bit         exp_done;
    bit         exp_inv;
    int         exp_writes;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int base;
    string nm;
    string msg;
    logic [7:0] rec [MSG_LEN];
    int bad_rec, bad_alpha;

    vecs[0] = '{0, 0, -1, 8'h00, 1'b1, 1'b0, 32};
    vecs[1] = '{0, 0,  5, 8'h41, 1'b0, 1'b1, 5};
    vecs[2] = '{1, 1, -1, 8'h00, 1'b1, 1'b0, 32};
    vecs[3] = '{2, 1, -1, 8'h00, 1'b1, 1'b0, 32};
    vecs[4] = '{2, 1, 31, 8'h7B, 1'b0, 1'b1, 31};
    vecs[5] = '{2, 1,  0, 8'h60, 1'b0, 1'b1, 0};
    vecs[6] = '{2, 2, -1, 8'h00, 1'b1, 1'b0, 32};
    vecs[7] = '{0, 1, 12, 8'h1F, 1'b0, 1'b1, 12};

    make_s(0);
    make_pt(0);
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({em_done, em_invalid, s_address, s_data, s_wren, pt_address, ct_address, ct_data, ct_wren}),
        64'(0));

    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d", v);
      make_s(vecs[v].s_kind);
      make_pt(vecs[v].pt_kind);
      if (vecs[v].bad_idx >= 0) pt_mem[vecs[v].bad_idx] = vecs[v].bad_val;
      load_and_reset();
      base = wr_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end(nm);
      chk({nm, "_done"}, 64'(em_done), 64'(vecs[v].exp_done));
      chk({nm, "_invalid"}, 64'(em_invalid), 64'(vecs[v].exp_inv));
      chk({nm, "_writes"}, 64'(wr_count - base), 64'(vecs[v].exp_writes));
      check_vs_model(nm, vecs[v].exp_writes);
      if (v == 0) begin
        chk("vec0_ct0", 64'(ct_mem[0]), 64'(8'h63));
        chk("vec0_ct1", 64'(ct_mem[1]), 64'(8'h64));
      end
    end

    // Reset during the first S[j] read, then a clean restart.
    make_s(2);
    make_pt(1);
    load_and_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_outputs",
        64'({em_done, em_invalid, s_address, s_data, s_wren, pt_address, ct_address, ct_data, ct_wren}),
        64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = wr_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("restart");
    chk("restart_done", 64'(em_done), 64'(1));
    chk("restart_writes", 64'(wr_count - base), 64'(32));
    check_vs_model("restart", 32);

    // Start held high across IDLE and DONE, then another pulse.
    make_s(2);
    make_pt(1);
    load_and_reset();
    base = wr_count;
    start = 1'b1;
    @(negedge clk);
    wait_end("held");
    repeat (60) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    chk("held_writes", 64'(wr_count - base), 64'(32));
    chk("held_done", 64'(em_done), 64'(1));
    chk("held_invalid", 64'(em_invalid), 64'(0));

    // KSA round trip with a real key and message.
    msg = "the quick brown fox jumps over  ";
    ksa(24'h000249);
    for (int k = 0; k < MSG_LEN; k++) pt_mem[k] = msg[k];
    load_and_reset();
    base = wr_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("ksa");
    chk("ksa_done", 64'(em_done), 64'(1));
    chk("ksa_writes", 64'(wr_count - base), 64'(32));
    check_vs_model("ksa", 32);
    ksa(24'h000249);
    for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
    for (int k = 0; k < MSG_LEN; k++) m_in[k] = ct_mem[k];
    model_rc4(1'b0);
    bad_rec = 0;
    bad_alpha = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      rec[k] = m_out[k];
      if (rec[k] !== msg[k]) bad_rec++;
      if (!legal(rec[k])) bad_alpha++;
    end
    chk("ksa_recovered_bytes_wrong", 64'(bad_rec), 64'(0));
    chk("ksa_decrypt_invalid_bytes", 64'(bad_alpha), 64'(0));

    chk("done_and_invalid_together", 64'(both_seen), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
